// File: rtl/fb_cmd_engine.sv
// fb_cmd_engine: executes rectangle fill, rectangle blit and sequential
// byte DMA read/write commands against a single-port 1-bit-per-pixel
// framebuffer RAM whose read data arrives one cycle after the address.
module fb_cmd_engine #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 200,
    parameter int DMA_BYTES = 8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  X1,
    input  logic [7:0]  Y1,
    input  logic [8:0]  X2,
    input  logic [7:0]  Y2,
    input  logic [8:0]  op_width,
    input  logic [7:0]  op_height,
    input  logic        start_blit,
    input  logic        start_fill,
    input  logic        fill_value,
    input  logic        start_read_ram,
    input  logic        start_write_ram,
    input  logic [7:0]  write_ram_byte,
    output logic        status,
    output logic        ram_byte_ready,
    output logic [7:0]  ram_byte,
    output logic [15:0] fb_addr,
    output logic        fb_we,
    output logic        fb_wdata,
    input  logic        fb_rdata
);

    // Clip limits at the widened coordinate widths so X+w never aliases.
    localparam logic [9:0]  MAX_X    = 10'(FB_WIDTH);
    localparam logic [8:0]  MAX_Y    = 9'(FB_HEIGHT);
    localparam logic [15:0] STRIDE   = 16'(FB_WIDTH);
    localparam logic [12:0] PTR_LAST = 13'(DMA_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        BLIT_RD,
        BLIT_WR,
        DMA_WR,
        DMA_RD,
        DMA_RD_LAST
    } state_t;

    state_t      state_reg;

    // Registered outputs
    logic        status_reg;
    logic        ram_byte_ready_reg;
    logic [7:0]  ram_byte_reg;
    logic [15:0] fb_addr_reg;
    logic        fb_we_reg;
    logic        fb_wdata_reg;

    // Latched operands
    logic [8:0]  ax_reg;
    logic [7:0]  ay_reg;
    logic [8:0]  bx_reg;
    logic [7:0]  by_reg;
    logic [8:0]  w_reg;
    logic [7:0]  h_reg;
    logic        fill_val_reg;

    // Rectangle walk position of the pixel currently on the bus
    logic [8:0]  col_reg;
    logic [7:0]  row_reg;
    logic        src_ok_reg;

    // DMA byte engine
    logic [12:0] ptr_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_reg;

    // Combinational helpers
    logic        row_end;
    logic        last_pix;
    logic [8:0]  next_col;
    logic [7:0]  next_row;
    logic [9:0]  src_x;
    logic [8:0]  src_y;
    logic [9:0]  dst_x;
    logic [8:0]  dst_y;
    logic        src_ok;
    logic        dst_ok;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [12:0] ptr_next;
    logic [15:0] dma_base;
    logic        zero_size;

    // Raster walk: where the next pixel lies and whether the current is last
    always_comb begin
        row_end  = (col_reg == w_reg - 9'd1);
        last_pix = row_end && (row_reg == h_reg - 8'd1);
        next_col = row_end ? 9'd0 : col_reg + 9'd1;
        next_row = row_end ? row_reg + 8'd1 : row_reg;
    end

    // Source/fill coordinate: the first pixel comes straight from the
    // operand inputs at acceptance, later ones from the latched origin.
    always_comb begin
        if (state_reg == IDLE) begin
            src_x = {1'b0, X1};
            src_y = {1'b0, Y1};
        end else begin
            src_x = {1'b0, ax_reg} + {1'b0, next_col};
            src_y = {1'b0, ay_reg} + {1'b0, next_row};
        end
        dst_x = {1'b0, bx_reg} + {1'b0, col_reg};
        dst_y = {1'b0, by_reg} + {1'b0, row_reg};
    end

    // Clip tests and linear pixel addresses (y*stride + x)
    always_comb begin
        src_ok   = (src_x < MAX_X) && (src_y < MAX_Y);
        dst_ok   = (dst_x < MAX_X) && (dst_y < MAX_Y);
        src_addr = src_ok ? (16'(src_y) * STRIDE + 16'(src_x)) : 16'd0;
        dst_addr = dst_ok ? (16'(dst_y) * STRIDE + 16'(dst_x)) : 16'd0;
    end

    // DMA pointer wrap and byte base address; zero-area rectangle detect
    always_comb begin
        ptr_next  = (ptr_reg == PTR_LAST) ? 13'd0 : ptr_reg + 13'd1;
        dma_base  = {ptr_reg, 3'b000};
        zero_size = (op_width == 9'd0) || (op_height == 8'd0);
    end

    // Command sequencer: accepts starts in IDLE, walks the operation, and
    // drives all framebuffer/host outputs from registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            status_reg         <= 1'b0;
            ram_byte_ready_reg <= 1'b0;
            ram_byte_reg       <= 8'h00;
            fb_addr_reg        <= 16'd0;
            fb_we_reg          <= 1'b0;
            fb_wdata_reg       <= 1'b0;
            ax_reg             <= 9'd0;
            ay_reg             <= 8'd0;
            bx_reg             <= 9'd0;
            by_reg             <= 8'd0;
            w_reg              <= 9'd0;
            h_reg              <= 8'd0;
            fill_val_reg       <= 1'b0;
            col_reg            <= 9'd0;
            row_reg            <= 8'd0;
            src_ok_reg         <= 1'b0;
            ptr_reg            <= 13'd0;
            shift_reg          <= 8'h00;
            bit_reg            <= 3'd0;
        end else begin
            ram_byte_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    fb_we_reg <= 1'b0;
                    if (start_blit || start_fill) begin
                        ax_reg       <= X1;
                        ay_reg       <= Y1;
                        bx_reg       <= X2;
                        by_reg       <= Y2;
                        w_reg        <= op_width;
                        h_reg        <= op_height;
                        fill_val_reg <= fill_value;
                        col_reg      <= 9'd0;
                        row_reg      <= 8'd0;
                        if (zero_size) begin
                            // Empty rectangle: the host uses this to rewind DMA
                            ptr_reg <= 13'd0;
                        end else if (start_blit) begin
                            state_reg   <= BLIT_RD;
                            status_reg  <= 1'b1;
                            fb_addr_reg <= src_addr;
                            src_ok_reg  <= src_ok;
                        end else begin
                            state_reg    <= FILL;
                            status_reg   <= 1'b1;
                            fb_addr_reg  <= src_addr;
                            fb_we_reg    <= src_ok;
                            fb_wdata_reg <= fill_value;
                        end
                    end else if (start_write_ram) begin
                        state_reg    <= DMA_WR;
                        status_reg   <= 1'b1;
                        fb_addr_reg  <= dma_base;
                        fb_we_reg    <= 1'b1;
                        fb_wdata_reg <= write_ram_byte[7];
                        shift_reg    <= {write_ram_byte[6:0], 1'b0};
                        bit_reg      <= 3'd0;
                    end else if (start_read_ram) begin
                        state_reg   <= DMA_RD;
                        status_reg  <= 1'b1;
                        fb_addr_reg <= dma_base;
                        bit_reg     <= 3'd0;
                    end
                end

                FILL: begin
                    if (last_pix) begin
                        state_reg  <= IDLE;
                        status_reg <= 1'b0;
                        fb_we_reg  <= 1'b0;
                        ptr_reg    <= 13'd0;
                    end else begin
                        col_reg      <= next_col;
                        row_reg      <= next_row;
                        fb_addr_reg  <= src_addr;
                        fb_we_reg    <= src_ok;
                        fb_wdata_reg <= fill_val_reg;
                    end
                end

                BLIT_RD: begin
                    // Source data appears on fb_rdata during the write cycle
                    state_reg   <= BLIT_WR;
                    fb_addr_reg <= dst_addr;
                    fb_we_reg   <= dst_ok;
                end

                BLIT_WR: begin
                    fb_we_reg <= 1'b0;
                    if (last_pix) begin
                        state_reg  <= IDLE;
                        status_reg <= 1'b0;
                        ptr_reg    <= 13'd0;
                    end else begin
                        state_reg   <= BLIT_RD;
                        col_reg     <= next_col;
                        row_reg     <= next_row;
                        fb_addr_reg <= src_addr;
                        src_ok_reg  <= src_ok;
                    end
                end

                DMA_WR: begin
                    if (bit_reg == 3'd7) begin
                        state_reg  <= IDLE;
                        status_reg <= 1'b0;
                        fb_we_reg  <= 1'b0;
                        ptr_reg    <= ptr_next;
                    end else begin
                        bit_reg      <= bit_reg + 3'd1;
                        fb_addr_reg  <= fb_addr_reg + 16'd1;
                        fb_wdata_reg <= shift_reg[7];
                        shift_reg    <= {shift_reg[6:0], 1'b0};
                    end
                end

                DMA_RD: begin
                    // Data for the previous address is valid now
                    if (bit_reg != 3'd0) begin
                        shift_reg <= {shift_reg[6:0], fb_rdata};
                    end
                    if (bit_reg == 3'd7) begin
                        state_reg <= DMA_RD_LAST;
                    end else begin
                        bit_reg     <= bit_reg + 3'd1;
                        fb_addr_reg <= fb_addr_reg + 16'd1;
                    end
                end

                DMA_RD_LAST: begin
                    ram_byte_reg       <= {shift_reg[6:0], fb_rdata};
                    ram_byte_ready_reg <= 1'b1;
                    status_reg         <= 1'b0;
                    state_reg          <= IDLE;
                    ptr_reg            <= ptr_next;
                end

                default: begin
                    state_reg  <= IDLE;
                    status_reg <= 1'b0;
                    fb_we_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Blit write data must come from the RAM in the same cycle it arrives,
    // so it bypasses the output register; out-of-range sources read as 0.
    always_comb begin
        if (state_reg == BLIT_WR) begin
            fb_wdata = src_ok_reg & fb_rdata;
        end else begin
            fb_wdata = fb_wdata_reg;
        end
    end

    assign status         = status_reg;
    assign ram_byte_ready = ram_byte_ready_reg;
    assign ram_byte       = ram_byte_reg;
    assign fb_addr        = fb_addr_reg;
    assign fb_we          = fb_we_reg;

endmodule

// File: tb/tb_fb_cmd_engine.sv
// Testbench for fb_cmd_engine: behavioural framebuffer RAM with registered
// read, a scoreboard of expected writes/read bytes, and one task per scenario.
module tb_fb_cmd_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  X1, X2, op_width;
    logic [7:0]  Y1, Y2, op_height;
    logic        start_blit, start_fill, fill_value;
    logic        start_read_ram, start_write_ram;
    logic [7:0]  write_ram_byte;
    logic        status, ram_byte_ready;
    logic [7:0]  ram_byte;
    logic [15:0] fb_addr;
    logic        fb_we, fb_wdata;
    logic        fb_rdata;

    // Framebuffer model and backdoor preload port
    bit          mem [0:63999];
    logic        pre_en = 1'b0;
    int          pre_addr = 0;
    logic        pre_val = 1'b0;

    // Scoreboard and monitor state
    logic [16:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int          status_cnt = 0;
    int          wr_cnt = 0;
    logic        status_q = 1'b0;
    logic [15:0] first_addr = 16'd0;
    int          n_checks = 0;
    int          n_fails = 0;

    always #5 clk = ~clk;

    fb_cmd_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .X1              (X1),
        .Y1              (Y1),
        .X2              (X2),
        .Y2              (Y2),
        .op_width        (op_width),
        .op_height       (op_height),
        .start_blit      (start_blit),
        .start_fill      (start_fill),
        .fill_value      (fill_value),
        .start_read_ram  (start_read_ram),
        .start_write_ram (start_write_ram),
        .write_ram_byte  (write_ram_byte),
        .status          (status),
        .ram_byte_ready  (ram_byte_ready),
        .ram_byte        (ram_byte),
        .fb_addr         (fb_addr),
        .fb_we           (fb_we),
        .fb_wdata        (fb_wdata),
        .fb_rdata        (fb_rdata)
    );

    // Single-port RAM, read-before-write, data one cycle after address
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_val;
        end else if (fb_we && fb_addr < 16'd64000) begin
            mem[fb_addr] <= fb_wdata;
        end
        fb_rdata <= (fb_addr < 16'd64000) ? mem[fb_addr] : 1'b0;
    end

    function automatic int addr_of(input int x, input int y);
        return y * 320 + x;
    endfunction

    task automatic push_wr(input int a, input logic v);
        exp_wr.push_back({16'(a), v});
    endtask

    task automatic push_byte(input int base, input logic [7:0] b);
        for (int k = 0; k < 8; k++) exp_wr.push_back({16'(base + k), b[7 - k]});
    endtask

    task automatic preload(input int a, input logic v);
        @(posedge clk); #1;
        pre_addr = a; pre_val = v; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Scoreboard monitor: pops an expectation for each DUT write / ready pulse
    task automatic scoreboard_monitor();
        logic [16:0] e;
        logic [7:0]  eb;
        forever begin
            @(negedge clk);
            if (status === 1'b1 && status_q !== 1'b1) first_addr = fb_addr;
            status_q = status;
            if (status === 1'b1) status_cnt++;
            if (fb_we === 1'b1) begin
                wr_cnt++;
                n_checks++;
                if (exp_wr.size() == 0) begin
                    n_fails++;
                    $display("FAIL wr_unexpected: got write addr=%0d data=%0b, expected no write", fb_addr, fb_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    if ({fb_addr, fb_wdata} !== e) begin
                        n_fails++;
                        $display("FAIL wr_data: got addr=%0d data=%0b, expected addr=%0d data=%0b",
                                 fb_addr, fb_wdata, e[16:1], e[0]);
                    end
                end
                $display("wr addr=%0d data=%0b", fb_addr, fb_wdata);
            end
            if (ram_byte_ready === 1'b1) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fails++;
                    $display("FAIL rd_unexpected: got ready with byte=%02h, expected no ready", ram_byte);
                end else begin
                    eb = exp_rd.pop_front();
                    if (ram_byte !== eb) begin
                        n_fails++;
                        $display("FAIL rd_byte: got %02h, expected %02h", ram_byte, eb);
                    end
                end
                $display("rd byte=%02h", ram_byte);
            end
        end
    endtask

    // One-cycle start pulse(s), then scramble operands to prove latching
    task automatic pulse(input bit b, input bit f, input bit w, input bit r);
        @(posedge clk); #1;
        start_blit = b; start_fill = f; start_write_ram = w; start_read_ram = r;
        @(posedge clk); #1;
        start_blit = 0; start_fill = 0; start_write_ram = 0; start_read_ram = 0;
        X1 = 9'($urandom); Y1 = 8'($urandom); X2 = 9'($urandom); Y2 = 8'($urandom);
        op_width = 9'($urandom); op_height = 8'($urandom);
        fill_value = 1'($urandom); write_ram_byte = 8'($urandom);
    endtask

    task automatic wait_idle(input int bound, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (status === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({status, ram_byte_ready, fb_we, fb_wdata} !== 4'b0000) begin
            n_fails++;
            $display("FAIL reset_flags: got status/ready/we/wdata=%04b, expected 0000",
                     {status, ram_byte_ready, fb_we, fb_wdata});
        end
        n_checks++;
        if (ram_byte !== 8'h00) begin
            n_fails++; $display("FAIL reset_ram_byte: got %02h, expected 00", ram_byte);
        end
        n_checks++;
        if (fb_addr !== 16'd0) begin
            n_fails++; $display("FAIL reset_fb_addr: got %0d, expected 0", fb_addr);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_fill();
        int s0, w0; bit to;
        X1 = 9'd10; Y1 = 8'd5; op_width = 9'd3; op_height = 8'd2; fill_value = 1'b1;
        for (int y = 5; y < 7; y++)
            for (int x = 10; x < 13; x++) push_wr(addr_of(x, y), 1'b1);
        s0 = status_cnt; w0 = wr_cnt;
        pulse(0, 1, 0, 0);
        wait_idle(50, to);
        n_checks++;
        if (to || status_cnt - s0 != 6 || wr_cnt - w0 != 6) begin
            n_fails++;
            $display("FAIL fill_timing: got status=%0d writes=%0d timeout=%0b, expected 6/6/0",
                     status_cnt - s0, wr_cnt - w0, to);
        end
        n_checks++;
        if (exp_wr.size() != 0) begin
            n_fails++; $display("FAIL fill_missing: got %0d writes outstanding, expected 0", exp_wr.size());
        end
    endtask

    task automatic test_blit();
        int s0; bit to;
        preload(0, 1'b1); preload(1, 1'b0); preload(100, 1'b0); preload(101, 1'b1);
        X1 = 9'd0; Y1 = 8'd0; X2 = 9'd100; Y2 = 8'd0; op_width = 9'd2; op_height = 8'd1;
        push_wr(100, 1'b1); push_wr(101, 1'b0);
        s0 = status_cnt;
        pulse(1, 0, 0, 0);
        wait_idle(50, to);
        n_checks++;
        if (to || status_cnt - s0 != 4) begin
            n_fails++; $display("FAIL blit_busy: got %0d cycles (timeout=%0b), expected 4", status_cnt - s0, to);
        end
        n_checks++;
        if (first_addr !== 16'd0 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL blit_reads: got first addr %0d, %0d writes outstanding, expected 0/0",
                                first_addr, exp_wr.size());
        end
    endtask

    task automatic test_blit_clip();
        int s0; bit to;
        preload(addr_of(319, 10), 1'b1); preload(addr_of(0, 11), 1'b1);
        X1 = 9'd319; Y1 = 8'd10; X2 = 9'd0; Y2 = 8'd20; op_width = 9'd2; op_height = 8'd1;
        push_wr(addr_of(0, 20), 1'b1); push_wr(addr_of(1, 20), 1'b0);
        s0 = status_cnt;
        pulse(1, 0, 0, 0);
        wait_idle(50, to);
        n_checks++;
        if (to || status_cnt - s0 != 4 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL blit_clip: got busy=%0d outstanding=%0d, expected 4/0",
                                status_cnt - s0, exp_wr.size());
        end
    endtask

    task automatic test_dma_write();
        int s0; bit to; logic [7:0] d;
        do_reset();
        d = 8'hA5; push_byte(0, d); write_ram_byte = d;
        s0 = status_cnt;
        pulse(0, 0, 1, 0);
        wait_idle(50, to);
        n_checks++;
        if (to || status_cnt - s0 != 8) begin
            n_fails++; $display("FAIL dma_wr_busy: got %0d cycles, expected 8", status_cnt - s0);
        end
        d = 8'hFF; push_byte(8, d); write_ram_byte = d;
        pulse(0, 0, 1, 0);
        wait_idle(50, to);
        n_checks++;
        if (to || first_addr !== 16'd8 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL dma_wr_second: got first addr %0d outstanding %0d, expected 8/0",
                                first_addr, exp_wr.size());
        end
    endtask

    task automatic test_dma_wrap();
        int s0, lat; bit to; logic [7:0] d, pat;
        do_reset();
        pat = 8'h3C;
        for (int k = 0; k < 8; k++) preload(63992 + k, pat[7 - k]);
        s0 = status_cnt;
        @(posedge clk); #1;
        d = 8'h5A; push_byte(0, d); write_ram_byte = d; start_write_ram = 1'b1;
        // start held high: each write is accepted on the first idle edge
        for (int i = 0; i < 7999; i++) begin
            @(posedge clk); #1;
            if (i == 7998) begin
                start_write_ram = 1'b0;
            end else begin
                d = 8'(i * 7 + 3); push_byte((i + 1) * 8, d); write_ram_byte = d;
            end
            repeat (8) @(posedge clk);
        end
        wait_idle(30, to);
        n_checks++;
        if (to || status_cnt - s0 != 7999 * 8 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL dma_bulk: got busy=%0d outstanding=%0d, expected %0d/0",
                                status_cnt - s0, exp_wr.size(), 7999 * 8);
        end
        exp_rd.push_back(pat);
        s0 = status_cnt;
        pulse(0, 0, 0, 1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ram_byte_ready === 1'b1) begin
                lat = n - 1;   // edges after the accepting edge
                break;
            end
        end
        n_checks++;
        if (lat != 9) begin
            n_fails++; $display("FAIL dma_rd_latency: got %0d edges, expected 9", lat);
        end
        wait_idle(30, to);
        n_checks++;
        if (to || first_addr !== 16'd63992 || status_cnt - s0 != 9) begin
            n_fails++; $display("FAIL dma_rd_last: got addr %0d busy %0d, expected 63992/9",
                                first_addr, status_cnt - s0);
        end
        d = 8'h5A; exp_rd.push_back(d);
        pulse(0, 0, 0, 1);
        wait_idle(30, to);
        @(negedge clk); #1;
        n_checks++;
        if (to || first_addr !== 16'd0 || exp_rd.size() != 0) begin
            n_fails++; $display("FAIL dma_rd_wrap: got addr %0d outstanding %0d, expected 0/0",
                                first_addr, exp_rd.size());
        end
    endtask

    task automatic test_fill_clip_rewind();
        int s0, w0; bit to; logic [7:0] d;
        X1 = 9'd318; Y1 = 8'd0; op_width = 9'd4; op_height = 8'd1; fill_value = 1'b1;
        push_wr(318, 1'b1); push_wr(319, 1'b1);
        s0 = status_cnt; w0 = wr_cnt;
        pulse(0, 1, 0, 0);
        wait_idle(30, to);
        n_checks++;
        if (to || status_cnt - s0 != 4 || wr_cnt - w0 != 2) begin
            n_fails++; $display("FAIL fill_clip: got busy=%0d writes=%0d, expected 4/2",
                                status_cnt - s0, wr_cnt - w0);
        end
        d = 8'hC3; push_byte(0, d); write_ram_byte = d;
        pulse(0, 0, 1, 0);
        wait_idle(30, to);
        X1 = 9'd7; Y1 = 8'd7; op_width = 9'd0; op_height = 8'd3;
        s0 = status_cnt;
        pulse(0, 1, 0, 0);
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (status_cnt - s0 != 0) begin
            n_fails++; $display("FAIL zero_fill_busy: got %0d busy cycles, expected 0", status_cnt - s0);
        end
        exp_rd.push_back(d);
        pulse(0, 0, 0, 1);
        wait_idle(30, to);
        @(negedge clk); #1;
        n_checks++;
        if (to || first_addr !== 16'd0 || exp_rd.size() != 0) begin
            n_fails++; $display("FAIL zero_fill_rewind: got addr %0d outstanding %0d, expected 0/0",
                                first_addr, exp_rd.size());
        end
    endtask

    task automatic test_priority();
        int s0; bit to;
        preload(addr_of(5, 100), 1'b1);
        X1 = 9'd5; Y1 = 8'd100; X2 = 9'd6; Y2 = 8'd100; op_width = 9'd1; op_height = 8'd1;
        fill_value = 1'b0; write_ram_byte = 8'h00;
        push_wr(addr_of(6, 100), 1'b1);
        s0 = status_cnt;
        pulse(1, 1, 1, 1);
        wait_idle(30, to);
        n_checks++;
        if (to || status_cnt - s0 != 2 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL prio_blit: got busy=%0d outstanding=%0d, expected 2/0",
                                status_cnt - s0, exp_wr.size());
        end
        X1 = 9'd20; Y1 = 8'd100; op_width = 9'd2; op_height = 8'd1; fill_value = 1'b1;
        push_wr(addr_of(20, 100), 1'b1); push_wr(addr_of(21, 100), 1'b1);
        s0 = status_cnt;
        pulse(0, 1, 1, 1);
        wait_idle(30, to);
        n_checks++;
        if (to || status_cnt - s0 != 2 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL prio_fill: got busy=%0d outstanding=%0d, expected 2/0",
                                status_cnt - s0, exp_wr.size());
        end
    endtask

    task automatic test_busy_and_reset();
        int s0, w0; bit to;
        X1 = 9'd0; Y1 = 8'd50; op_width = 9'd5; op_height = 8'd1; fill_value = 1'b1;
        for (int x = 0; x < 5; x++) push_wr(addr_of(x, 50), 1'b1);
        s0 = status_cnt; w0 = wr_cnt;
        pulse(0, 1, 0, 0);
        X1 = 9'd200; Y1 = 8'd60; op_width = 9'd3; op_height = 8'd1; fill_value = 1'b0;
        pulse(0, 1, 0, 0);
        wait_idle(30, to);
        n_checks++;
        if (to || status_cnt - s0 != 5 || wr_cnt - w0 != 5) begin
            n_fails++; $display("FAIL busy_drop: got busy=%0d writes=%0d, expected 5/5",
                                status_cnt - s0, wr_cnt - w0);
        end
        X1 = 9'd0; Y1 = 8'd150; op_width = 9'd100; op_height = 8'd1; fill_value = 1'b1;
        for (int x = 0; x < 3; x++) push_wr(addr_of(x, 150), 1'b1);
        w0 = wr_cnt;
        pulse(0, 1, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fb_we !== 1'b0 || status !== 1'b0 || ram_byte_ready !== 1'b0) begin
            n_fails++; $display("FAIL reset_midop: got we=%0b status=%0b ready=%0b, expected 0/0/0",
                                fb_we, status, ram_byte_ready);
        end
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (wr_cnt - w0 != 3 || exp_wr.size() != 0) begin
            n_fails++; $display("FAIL reset_abandon: got %0d writes outstanding %0d, expected 3/0",
                                wr_cnt - w0, exp_wr.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        X1 = '0; Y1 = '0; X2 = '0; Y2 = '0; op_width = '0; op_height = '0;
        start_blit = 0; start_fill = 0; fill_value = 0;
        start_read_ram = 0; start_write_ram = 0; write_ram_byte = '0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_fill();
        test_blit();
        test_blit_clip();
        test_dma_write();
        test_dma_wrap();
        test_fill_clip_rewind();
        test_priority();
        test_busy_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
